// File: rtl/mem_pkg.sv
// Shared encodings for the memory access stage: access sizes, FSM states, fault codes.
package mem_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [1:0] FLT_NONE     = 2'd0;
    localparam logic [1:0] FLT_MISALIGN = 2'd1;
    localparam logic [1:0] FLT_TIMEOUT  = 2'd2;

    // Dword accesses only exist on a 64-bit datapath.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] lo,
                                           input logic has_dword);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return lo[0];
            SZ_W:    return |lo[1:0];
            default: return !has_dword || (|lo);
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane formatting: byte enables and positioned store data, plus shifted and
// sign/zero-extended load data. Purely combinational.
module lsu_align
    import mem_pkg::*;
#(
    parameter int DATA_W = 32,
    localparam int BE_W  = DATA_W / 8,
    localparam int OFF_W = $clog2(BE_W)
) (
    input  logic [1:0]        i_size,
    input  logic [OFF_W-1:0]  i_off,
    input  logic              i_unsigned,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [DATA_W-1:0] i_rdata,
    output logic [BE_W-1:0]   o_be,
    output logic [DATA_W-1:0] o_wdata,
    output logic [DATA_W-1:0] o_ld_val
);

    logic [3:0]        w_nbytes;
    logic [BE_W-1:0]   w_lanes;
    logic [DATA_W-1:0] w_bitmask;
    logic [DATA_W-1:0] w_shifted;
    logic              w_sign;

    always_comb begin
        w_nbytes  = 4'd1 << i_size;
        w_lanes   = '0;
        w_bitmask = '0;
        for (int b = 0; b < BE_W; b++) begin
            w_lanes[b]          = (4'(b) < w_nbytes);
            w_bitmask[8*b +: 8] = {8{w_lanes[b]}};
        end
        w_shifted = (i_rdata >> {i_off, 3'b000}) & w_bitmask;
        case (i_size)
            SZ_B:    w_sign = w_shifted[7];
            SZ_H:    w_sign = w_shifted[15];
            SZ_W:    w_sign = w_shifted[31];
            default: w_sign = w_shifted[DATA_W-1];
        endcase
        o_be     = w_lanes << i_off;
        o_wdata  = (i_wdata & w_bitmask) << {i_off, 3'b000};
        o_ld_val = (w_sign && !i_unsigned) ? (w_shifted | ~w_bitmask) : w_shifted;
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory pipeline stage: one op in flight, 2+ cycles for load/store, 1 for pass-through/fault.
// in_ready only in IDLE; results held until out_ready; dmem request held until ack or timeout.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_ld,
    input  logic                in_str,
    input  logic [1:0]          in_size,
    input  logic                in_unsigned,
    input  logic [ADDR_W-1:0]   in_addr,
    input  logic [DATA_W-1:0]   in_data,
    input  logic [4:0]          in_rd_num,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_val,
    output logic [4:0]          out_rd_num,
    output logic                out_we,
    output logic [1:0]          out_fault,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic [ADDR_W-1:0]   dmem_addr,
    output logic [DATA_W-1:0]   dmem_wdata,
    output logic [DATA_W/8-1:0] dmem_be,
    input  logic                dmem_ack,
    input  logic [DATA_W-1:0]   dmem_rdata
);

    localparam int BE_W   = DATA_W / 8;
    localparam int OFF_W  = $clog2(BE_W);
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    logic [1:0]        r_state;
    logic              r_in_rdy;
    logic [WAIT_W-1:0] r_wait;
    logic              r_is_ld;
    logic [1:0]        r_size;
    logic [OFF_W-1:0]  r_off;
    logic              r_unsigned;
    logic [4:0]        r_rd;
    logic              r_out_vld;
    logic [DATA_W-1:0] r_out_val;
    logic              r_out_we;
    logic [1:0]        r_out_fault;
    logic              r_req;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [BE_W-1:0]   r_be;

    logic [1:0]        w_state_nxt;
    logic              w_is_mem;
    logic              w_misalign;
    logic              w_wait_done;
    logic [1:0]        w_size;
    logic [OFF_W-1:0]  w_off;
    logic [BE_W-1:0]   w_be;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_ld_val;

    // Both ld and str high is not a memory op; it falls through as pass-through.
    assign w_is_mem    = in_ld ^ in_str;
    assign w_misalign  = is_misaligned(in_size, in_addr[2:0], DATA_W == 64);
    assign w_wait_done = (r_wait == WAIT_W'(MAX_WAIT - 1));

    // Lane formatter sees the incoming op in IDLE and the captured op while waiting.
    assign w_size = (r_state == IDLE) ? in_size : r_size;
    assign w_off  = (r_state == IDLE) ? in_addr[OFF_W-1:0] : r_off;

    lsu_align #(.DATA_W(DATA_W)) u_align (
        .i_size     (w_size),
        .i_off      (w_off),
        .i_unsigned (r_unsigned),
        .i_wdata    (in_data),
        .i_rdata    (dmem_rdata),
        .o_be       (w_be),
        .o_wdata    (w_wdata),
        .o_ld_val   (w_ld_val)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_state_nxt = (w_is_mem && !w_misalign) ? REQ : RESP;
            REQ:     if (dmem_ack || w_wait_done) w_state_nxt = RESP;
            RESP:    if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_in_rdy    <= 1'b0;
            r_wait      <= '0;
            r_is_ld     <= 1'b0;
            r_size      <= SZ_B;
            r_off       <= '0;
            r_unsigned  <= 1'b0;
            r_rd        <= '0;
            r_out_vld   <= 1'b0;
            r_out_val   <= '0;
            r_out_we    <= 1'b0;
            r_out_fault <= FLT_NONE;
            r_req       <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_be        <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_in_rdy <= (w_state_nxt == IDLE);
            case (r_state)
                IDLE: if (in_valid) begin
                    r_rd       <= in_rd_num;
                    r_is_ld    <= in_ld;
                    r_size     <= in_size;
                    r_off      <= in_addr[OFF_W-1:0];
                    r_unsigned <= in_unsigned;
                    r_wait     <= '0;
                    if (!w_is_mem) begin
                        r_out_vld   <= 1'b1;
                        r_out_val   <= in_data;
                        r_out_we    <= 1'b1;
                        r_out_fault <= FLT_NONE;
                    end else if (w_misalign) begin
                        r_out_vld   <= 1'b1;
                        r_out_val   <= '0;
                        r_out_we    <= 1'b0;
                        r_out_fault <= FLT_MISALIGN;
                    end else begin
                        r_req   <= 1'b1;
                        r_we    <= in_str;
                        r_addr  <= {in_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        r_wdata <= in_str ? w_wdata : '0;
                        r_be    <= w_be;
                    end
                end
                // An ack on the final counted cycle takes priority over the timeout.
                REQ: if (dmem_ack) begin
                    r_req       <= 1'b0;
                    r_we        <= 1'b0;
                    r_out_vld   <= 1'b1;
                    r_out_val   <= r_is_ld ? w_ld_val : '0;
                    r_out_we    <= r_is_ld;
                    r_out_fault <= FLT_NONE;
                end else if (w_wait_done) begin
                    r_req       <= 1'b0;
                    r_we        <= 1'b0;
                    r_out_vld   <= 1'b1;
                    r_out_val   <= '0;
                    r_out_we    <= 1'b0;
                    r_out_fault <= FLT_TIMEOUT;
                end else begin
                    r_wait <= r_wait + WAIT_W'(1);
                end
                RESP: if (out_ready) begin
                    r_out_vld <= 1'b0;
                    r_out_we  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign in_ready   = r_in_rdy;
    assign out_valid  = r_out_vld;
    assign out_val    = r_out_val;
    assign out_rd_num = r_rd;
    assign out_we     = r_out_we;
    assign out_fault  = r_out_fault;
    assign dmem_req   = r_req;
    assign dmem_we    = r_we;
    assign dmem_addr  = r_addr;
    assign dmem_wdata = r_wdata;
    assign dmem_be    = r_be;

endmodule
